// File: rtl/coin_bank_pkg.sv
// coin_bank_pkg: scancodes, FSM states and the saturating add
// shared by the credit bank and anything that decodes its keys.
package coin_bank_pkg;

    localparam logic [8:0] KEY_0     = 9'h045;
    localparam logic [8:0] KEY_5     = 9'h02E;
    localparam logic [8:0] KEY_1     = 9'h016;
    localparam logic [8:0] KEY_2     = 9'h01E;
    localparam logic [8:0] KEY_3     = 9'h026;
    localparam logic [8:0] KEY_QMARK = 9'h04A;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        PLAYING,
        PAYOUT
    } state_e;

    // Sum in 8 bits so that a 7-bit overflow still compares against max.
    function automatic logic [6:0] sat_add7(
        input logic [6:0] a,
        input logic [6:0] b,
        input logic [6:0] max
    );
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max}) begin
            return max;
        end
        return s[6:0];
    endfunction

endpackage

// File: rtl/coin_bank.sv
// coin_bank: owns the player's credit balance, takes coins and level
// selections from the keyboard and pays the reward when a game ends.
//   in : clk, rst (sync, active high), keydown, last_change[8:0],
//        game_over, win, reward_amt[6:0]
//   out: money[6:0], ready, charged, busy_game
//   COIN_BANK_CASHOUT_EN adds cashout / cashout_amt[6:0] (ESC empties bank)
module coin_bank
    import coin_bank_pkg::*;
#(
    parameter int MAX_MONEY  = 99,
    parameter int GAME_COST  = 10,
    parameter int COIN_SMALL = 5,
    parameter int COIN_LARGE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keydown,
    input  logic [8:0] last_change,
    input  logic       game_over,
    input  logic       win,
    input  logic [6:0] reward_amt,
    output logic [6:0] money,
    output logic       ready,
    output logic       charged,
    output logic       busy_game
`ifdef COIN_BANK_CASHOUT_EN
    ,
    output logic       cashout,
    output logic [6:0] cashout_amt
`endif
);

    localparam logic [6:0] MAX7   = MAX_MONEY[6:0];
    localparam logic [6:0] COST7  = GAME_COST[6:0];
    localparam logic [6:0] SMALL7 = COIN_SMALL[6:0];
    localparam logic [6:0] LARGE7 = COIN_LARGE[6:0];

    state_e     state_q, state_d;
    logic [6:0] money_q, money_d;
    logic [6:0] pay_q, pay_d;
    logic       ready_q, ready_d;
    logic       charged_q, charged_d;
    logic       busy_q, busy_d;
`ifdef COIN_BANK_CASHOUT_EN
    logic       cash_q, cash_d;
    logic [6:0] cash_amt_q, cash_amt_d;
`endif

    logic is_sel;
    assign is_sel = (last_change == KEY_1) ||
                    (last_change == KEY_2) ||
                    (last_change == KEY_3);

    always_comb begin
        state_d = state_q;
        money_d = money_q;
        pay_d   = pay_q;
`ifdef COIN_BANK_CASHOUT_EN
        cash_d     = 1'b0;
        cash_amt_d = cash_amt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (keydown) begin
                    if (last_change == KEY_5) begin
                        money_d = sat_add7(money_q, SMALL7, MAX7);
                    end else if (last_change == KEY_0) begin
                        money_d = sat_add7(money_q, LARGE7, MAX7);
                    end else if (is_sel && money_q >= COST7) begin
                        state_d = CHARGE;
                    end
`ifdef COIN_BANK_CASHOUT_EN
                    else if (last_change == KEY_ESC &&
                             money_q != 7'd0) begin
                        cash_d     = 1'b1;
                        cash_amt_d = money_q;
                        money_d    = 7'd0;
                    end
`endif
                end
            end
            CHARGE: begin
                // Entered only with money >= cost, so no underflow.
                money_d = money_q - COST7;
                state_d = PLAYING;
            end
            PLAYING: begin
                if (game_over) begin
                    pay_d   = win ? reward_amt : 7'd0;
                    state_d = PAYOUT;
                end
            end
            PAYOUT: begin
                money_d = sat_add7(money_q, pay_q, MAX7);
                pay_d   = 7'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up
        // with the state they describe.
        ready_d   = (state_d == IDLE);
        charged_d = (state_d == CHARGE);
        busy_d    = (state_d == PLAYING) || (state_d == PAYOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            money_q   <= 7'd0;
            pay_q     <= 7'd0;
            ready_q   <= 1'b0;
            charged_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef COIN_BANK_CASHOUT_EN
            cash_q     <= 1'b0;
            cash_amt_q <= 7'd0;
`endif
        end else begin
            state_q   <= state_d;
            money_q   <= money_d;
            pay_q     <= pay_d;
            ready_q   <= ready_d;
            charged_q <= charged_d;
            busy_q    <= busy_d;
`ifdef COIN_BANK_CASHOUT_EN
            cash_q     <= cash_d;
            cash_amt_q <= cash_amt_d;
`endif
        end
    end

    assign money     = money_q;
    assign ready     = ready_q;
    assign charged   = charged_q;
    assign busy_game = busy_q;
`ifdef COIN_BANK_CASHOUT_EN
    assign cashout     = cash_q;
    assign cashout_amt = cash_amt_q;
`endif

endmodule

// File: tb/tb_coin_bank.sv
// tb_coin_bank: directed test-plan sequence plus random key/game traffic,
// every cycle's outputs checked from a queue filled by the stimulus side.
module tb_coin_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       keydown = 1'b0;
    logic [8:0] last_change = 9'h000;
    logic       game_over = 1'b0;
    logic       win = 1'b0;
    logic [6:0] reward_amt = 7'd0;
    logic [6:0] money;
    logic       ready;
    logic       charged;
    logic       busy_game;
`ifdef COIN_BANK_CASHOUT_EN
    logic       cashout;
    logic [6:0] cashout_amt;
`endif

    coin_bank dut (
        .clk         (clk),
        .rst         (rst),
        .keydown     (keydown),
        .last_change (last_change),
        .game_over   (game_over),
        .win         (win),
        .reward_amt  (reward_amt),
        .money       (money),
        .ready       (ready),
        .charged     (charged),
        .busy_game   (busy_game)
`ifdef COIN_BANK_CASHOUT_EN
        ,
        .cashout     (cashout),
        .cashout_amt (cashout_amt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        int         money;
        bit         chk_money;
        bit         ready;
        bit         busy;
        bit         charged;
        bit         cash;
        int         cash_amt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: balance and whether a game is running.
    int m_money = 0;
    bit m_play  = 0;

    function automatic int sat(input int x);
        return (x > 99) ? 99 : x;
    endfunction

    task automatic push(input string tag, input int mny, input bit chk_m,
                        input bit rdy, input bit bsy, input bit chg,
                        input bit csh = 0, input int camt = 0);
        exp_t e;
        e.due = cyc;
        e.tag = tag;
        e.money = mny;
        e.chk_money = chk_m;
        e.ready = rdy;
        e.busy = bsy;
        e.charged = chg;
        e.cash = csh;
        e.cash_amt = camt;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs; returns 1ns after the sampling edge.
    task automatic apply(input bit r, input bit kd, input logic [8:0] code,
                         input bit go, input bit w, input logic [6:0] amt);
        rst = r;
        keydown = kd;
        last_change = code;
        game_over = go;
        win = w;
        reward_amt = amt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        keydown = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic do_reset();
        apply(1, 0, 9'h000, 0, 0, 7'd0);
        push("reset", 0, 1, 0, 0, 0);
        m_money = 0;
        m_play = 0;
        apply(0, 0, 9'h000, 0, 0, 7'd0);
        push("ready_after_reset", 0, 1, 1, 0, 0);
    endtask

    task automatic op(input bit kd, input logic [8:0] code,
                      input bit go, input bit w, input logic [6:0] amt);
        bit sel;
        int pay;
        sel = kd && (code == 9'h016 || code == 9'h01E || code == 9'h026);
        apply(0, kd, code, go, w, amt);
        if (!m_play) begin
            if (kd && code == 9'h02E) begin
                m_money = sat(m_money + 5);
                push("coin5", m_money, 1, 1, 0, 0);
            end else if (kd && code == 9'h045) begin
                m_money = sat(m_money + 10);
                push("coin10", m_money, 1, 1, 0, 0);
            end else if (sel && m_money >= 10) begin
                push("charge_pulse", m_money, 0, 0, 0, 1);
                apply(0, 0, 9'h000, 0, 0, 7'd0);
                m_money = m_money - 10;
                m_play = 1;
                push("playing", m_money, 1, 0, 1, 0);
            end
`ifdef COIN_BANK_CASHOUT_EN
            else if (kd && code == 9'h076 && m_money > 0) begin
                push("cashout", 0, 1, 1, 0, 0, 1, m_money);
                m_money = 0;
            end
`endif
            else begin
                push("idle_nochange", m_money, 1, 1, 0, 0);
            end
        end else begin
            if (go) begin
                pay = w ? int'(amt) : 0;
                push("payout", m_money, 0, 0, 1, 0);
                apply(0, 0, 9'h000, 0, 0, 7'd0);
                m_money = sat(m_money + pay);
                m_play = 0;
                push("back_idle", m_money, 1, 1, 0, 0);
            end else begin
                push("play_ignore", m_money, 1, 0, 1, 0);
            end
        end
    endtask

    task automatic key(input logic [8:0] code);
        op(1, code, 0, 0, 7'd0);
    endtask

    task automatic end_game(input bit w, input logic [6:0] amt);
        op(0, 9'h000, 1, w, amt);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            bit bad;
            e = q.pop_front();
            checks++;
            bad = (e.due != cyc) ||
                  (ready !== e.ready) ||
                  (busy_game !== e.busy) ||
                  (charged !== e.charged) ||
                  (e.chk_money && money !== 7'(e.money));
`ifdef COIN_BANK_CASHOUT_EN
            bad = bad || (cashout !== e.cash) ||
                  (e.cash && cashout_amt !== 7'(e.cash_amt));
`endif
            if (bad) begin
                errors++;
                $display("FAIL %s cyc=%0d got money=%0d ready=%b busy=%b charged=%b exp money=%0d(chk=%0b) ready=%b busy=%b charged=%b",
                         e.tag, cyc, money, ready, busy_game, charged,
                         e.money, e.chk_money, e.ready, e.busy, e.charged);
            end
        end
    end

    localparam logic [8:0] CODES [9] = '{
        9'h045, 9'h02E, 9'h016, 9'h01E, 9'h026,
        9'h04A, 9'h076, 9'h045, 9'h02E
    };

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        key(9'h045);
        key(9'h045);
        key(9'h02E);
        repeat (7) key(9'h045);
        key(9'h045);
        key(9'h02E);

        do_reset();
        key(9'h045);
        key(9'h045);
        key(9'h02E);
        key(9'h01E);
        key(9'h02E);
        end_game(1, 7'd40);
        key(9'h01E);
        end_game(0, 7'd40);

        do_reset();
        key(9'h045);
        key(9'h016);
        end_game(1, 7'd8);
        key(9'h016);
        key(9'h045);
        key(9'h016);
        end_game(1, 7'd42);
        key(9'h04A);
        op(1, 9'h045, 1, 1, 7'd20);
        key(9'h01E);
        op(1, 9'h045, 1, 1, 7'd0);
        key(9'h01E);
        do_reset();

`ifdef COIN_BANK_CASHOUT_EN
        key(9'h076);
        key(9'h045);
        key(9'h045);
        key(9'h045);
        key(9'h02E);
        key(9'h076);
`endif

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [8:0] code;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0)
                    code = 9'($urandom_range(0, 511));
                else
                    code = CODES[$urandom_range(0, 8)];
                op($urandom_range(0, 4) != 0, code,
                   $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)));
            end
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
